// File: rtl/wrr_tlp_framer.sv
// -----------------------------------------------------------------------------
// wrr_tlp_framer
//
// Purpose:
//   Lane framer that sits behind the weighted-round-robin VC arbiter. Each TLP
//   granted by the arbiter goes onto the lane as
//       STP, {6'b0, vc}, payload bytes ..., END
//   Idle cycles carry IDL. A SKP ordered set (COM + 3 x SKP) is requested every
//   SKP_INTERVAL cycles and is only sent between frames. Every output is a
//   flop, so a decision taken in one cycle is visible after the next edge.
//
// Parameters:
//   SKP_INTERVAL  cycles between SKP ordered-set requests (8..1023)
//   MAX_LEN       maximum payload bytes per frame (1..255)
//
// Optional feature (compile-time macro WRR_EDB_EN):
//   defined   : grant_abort in the payload phase nullifies the frame with EDB,
//               and a MAX_LEN overrun also closes the frame with EDB.
//   undefined : grant_abort is ignored, an overrun closes the frame with END,
//               and EDB is never emitted.
//
// Ports:
//   clk          single clock for all state
//   reset        asynchronous, active-high reset
//   grant_valid  arbiter presents a byte of the granted VC
//   grant_vc     VC of the grant, captured when the frame starts
//   grant_data   payload byte
//   grant_last   final byte of the TLP
//   grant_abort  arbiter nullifies the TLP in flight (WRR_EDB_EN builds only)
//   grant_ready  framer consumes grant_data this cycle (high only in payload)
//   out_sym      lane symbol
//   out_k        1 = out_sym is a K/control symbol
//   frame_err    sticky flag, set when a frame overruns MAX_LEN
// -----------------------------------------------------------------------------
module wrr_tlp_framer #(
    parameter int SKP_INTERVAL = 64,
    parameter int MAX_LEN      = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       grant_valid,
    input  logic [1:0] grant_vc,
    input  logic [7:0] grant_data,
    input  logic       grant_last,
    input  logic       grant_abort,
    output logic       grant_ready,
    output logic [7:0] out_sym,
    output logic       out_k,
    output logic       frame_err
);

    // Lane symbol codes
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_PAD = 8'hC7;
    localparam logic [7:0] SYM_SKP = 8'hAC;
    localparam logic [7:0] SYM_STP = 8'hAA;
    localparam logic [7:0] SYM_END = 8'hF6;
    localparam logic [7:0] SYM_EDB = 8'hDF;
    localparam logic [7:0] SYM_IDL = 8'hAE;

`ifdef WRR_EDB_EN
    localparam bit EDB_EN = 1'b1;
`else
    localparam bit EDB_EN = 1'b0;
`endif

    // Terminal counts, sized to the counters they are compared with
    localparam logic [9:0] SKP_CNT_LAST = 10'(SKP_INTERVAL - 1);
    localparam logic [7:0] LEN_LAST     = 8'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_END,
        ST_SKP0,
        ST_SKP1,
        ST_SKP2,
        ST_SKP3
    } state_t;

    state_t     state_reg;
    logic [1:0] vc_reg;
    logic [7:0] len_cnt_reg;
    logic [9:0] skp_cnt_reg;
    logic       skp_pend_reg;
    logic       edb_reg;          // END state closes with EDB instead of END

    logic [7:0] out_sym_reg;
    logic       out_k_reg;
    logic       grant_ready_reg;
    logic       frame_err_reg;

    logic       skp_expire;
    logic       abort_now;

    assign skp_expire = (skp_cnt_reg == SKP_CNT_LAST);

    // Without the EDB feature the abort input is masked off entirely.
    assign abort_now  = EDB_EN & grant_abort;

    assign out_sym     = out_sym_reg;
    assign out_k       = out_k_reg;
    assign grant_ready = grant_ready_reg;
    assign frame_err   = frame_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            vc_reg          <= 2'd0;
            len_cnt_reg     <= 8'd0;
            skp_cnt_reg     <= 10'd0;
            skp_pend_reg    <= 1'b0;
            edb_reg         <= 1'b0;
            out_sym_reg     <= SYM_IDL;
            out_k_reg       <= 1'b1;
            grant_ready_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            // Free-running SKP scheduler. An expiry while a request is
            // already pending simply leaves it pending.
            if (skp_expire) begin
                skp_cnt_reg  <= 10'd0;
                skp_pend_reg <= 1'b1;
            end else begin
                skp_cnt_reg  <= skp_cnt_reg + 10'd1;
            end

            // grant_ready is only re-armed on paths that stay in (or enter)
            // the payload phase; every other path drops it.
            grant_ready_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    out_sym_reg <= SYM_IDL;
                    out_k_reg   <= 1'b1;
                    if (skp_pend_reg) begin
                        // SKP wins over a waiting frame. A fresh expiry in
                        // this same cycle is kept as a new request.
                        state_reg <= ST_SKP0;
                        if (!skp_expire) begin
                            skp_pend_reg <= 1'b0;
                        end
                    end else if (grant_valid) begin
                        out_sym_reg <= SYM_STP;
                        vc_reg      <= grant_vc;
                        len_cnt_reg <= 8'd0;
                        edb_reg     <= 1'b0;
                        state_reg   <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    out_sym_reg     <= {6'b0, vc_reg};
                    out_k_reg       <= 1'b0;
                    grant_ready_reg <= 1'b1;
                    state_reg       <= ST_PAY;
                end

                ST_PAY: begin
                    if (abort_now) begin
                        // Nullified TLP: the presented byte is dropped and
                        // EDB goes out in its place.
                        out_sym_reg <= SYM_EDB;
                        out_k_reg   <= 1'b1;
                        len_cnt_reg <= 8'd0;
                        state_reg   <= ST_IDLE;
                    end else if (grant_valid) begin
                        out_sym_reg <= grant_data;
                        out_k_reg   <= 1'b0;
                        len_cnt_reg <= len_cnt_reg + 8'd1;
                        if (grant_last) begin
                            // Includes last on the MAX_LEN-th byte: legal.
                            state_reg <= ST_END;
                        end else if (len_cnt_reg == LEN_LAST) begin
                            // MAX_LEN bytes taken with no end in sight: stop
                            // consuming and close the frame. The rest of the
                            // arbiter's TLP becomes the next frame.
                            frame_err_reg <= 1'b1;
                            edb_reg       <= EDB_EN;
                            state_reg     <= ST_END;
                        end else begin
                            grant_ready_reg <= 1'b1;
                        end
                    end else begin
                        // Underrun filler keeps the lane busy inside a frame
                        out_sym_reg     <= SYM_PAD;
                        out_k_reg       <= 1'b1;
                        grant_ready_reg <= 1'b1;
                    end
                end

                ST_END: begin
                    out_sym_reg <= edb_reg ? SYM_EDB : SYM_END;
                    out_k_reg   <= 1'b1;
                    len_cnt_reg <= 8'd0;
                    edb_reg     <= 1'b0;
                    state_reg   <= ST_IDLE;
                end

                ST_SKP0: begin
                    out_sym_reg <= SYM_COM;
                    out_k_reg   <= 1'b1;
                    state_reg   <= ST_SKP1;
                end

                ST_SKP1: begin
                    out_sym_reg <= SYM_SKP;
                    out_k_reg   <= 1'b1;
                    state_reg   <= ST_SKP2;
                end

                ST_SKP2: begin
                    out_sym_reg <= SYM_SKP;
                    out_k_reg   <= 1'b1;
                    state_reg   <= ST_SKP3;
                end

                ST_SKP3: begin
                    out_sym_reg <= SYM_SKP;
                    out_k_reg   <= 1'b1;
                    state_reg   <= ST_IDLE;
                end

                default: begin
                    out_sym_reg <= SYM_IDL;
                    out_k_reg   <= 1'b1;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_tlp_framer.sv
// -----------------------------------------------------------------------------
// tb_wrr_tlp_framer
//
// Two framer instances share clock and reset:
//   dut_a : SKP_INTERVAL=1000, MAX_LEN=4   (frame content, gaps, overrun, abort)
//   dut_b : SKP_INTERVAL=8,    MAX_LEN=32  (SKP placement)
// Lane output is captured each negedge into queues and compared against
// hand-written symbol lists ({k, sym}, 9 bits).
// -----------------------------------------------------------------------------
module tb_wrr_tlp_framer;

    localparam logic [8:0] K_IDL = 9'h1AE;
    localparam logic [8:0] K_STP = 9'h1AA;
    localparam logic [8:0] K_END = 9'h1F6;
    localparam logic [8:0] K_COM = 9'h1BC;
    localparam logic [8:0] K_SKP = 9'h1AC;
    localparam logic [8:0] K_PAD = 9'h1C7;
`ifdef WRR_EDB_EN
    localparam logic [8:0] K_OVR = 9'h1DF;
`else
    localparam logic [8:0] K_OVR = 9'h1F6;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_valid, a_last, a_abort, a_ready, a_k, a_err;
    logic [1:0] a_vc;
    logic [7:0] a_data, a_sym;
    logic       b_valid, b_last, b_abort, b_ready, b_k, b_err;
    logic [1:0] b_vc;
    logic [7:0] b_data, b_sym;

    wrr_tlp_framer #(.SKP_INTERVAL(1000), .MAX_LEN(4)) dut_a (
        .clk(clk), .reset(reset),
        .grant_valid(a_valid), .grant_vc(a_vc), .grant_data(a_data),
        .grant_last(a_last), .grant_abort(a_abort), .grant_ready(a_ready),
        .out_sym(a_sym), .out_k(a_k), .frame_err(a_err)
    );

    wrr_tlp_framer #(.SKP_INTERVAL(8), .MAX_LEN(32)) dut_b (
        .clk(clk), .reset(reset),
        .grant_valid(b_valid), .grant_vc(b_vc), .grant_data(b_data),
        .grant_last(b_last), .grant_abort(b_abort), .grant_ready(b_ready),
        .out_sym(b_sym), .out_k(b_k), .frame_err(b_err)
    );

    int total = 0;
    int bad   = 0;

    logic       cap_en = 1'b0;
    logic [8:0] cap_a[$];
    logic [8:0] cap_b[$];
    logic [8:0] exp_q[$];

    always @(negedge clk) begin
        if (cap_en) begin
            cap_a.push_back({a_k, a_sym});
            cap_b.push_back({b_k, b_sym});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Skip leading IDL on dut_a's capture, then match exp_q element by element.
    task automatic check_stream(input string tag);
        int i;
        i = 0;
        while (i < cap_a.size() && cap_a[i] == K_IDL) i++;
        check({tag, "_len"}, 32'(cap_a.size() >= i + exp_q.size()), 32'd1);
        for (int j = 0; j < exp_q.size(); j++) begin
            if (i + j < cap_a.size())
                check($sformatf("%s[%0d]", tag, j), 32'(cap_a[i + j]), 32'(exp_q[j]));
        end
    endtask

    task automatic do_reset();
        cap_en = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b1;
        a_valid = 1'b0; a_last = 1'b0; a_abort = 1'b0;
        b_valid = 1'b0; b_last = 1'b0; b_abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cap_a.delete();
        cap_b.delete();
        cap_en = 1'b1;
    endtask

    // Present one byte on lane sel (0=a, 1=b) until it is taken.
    task automatic push(input bit sel, input logic [7:0] d, input bit last);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        if (sel) begin b_valid = 1'b1; b_data = d; b_last = last; end
        else     begin a_valid = 1'b1; a_data = d; a_last = last; end
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = sel ? b_ready : a_ready;
            n++;
            @(posedge clk); #1;
        end
        check($sformatf("push_accept_%0h", d), 32'(acc), 32'd1);
        if (sel) begin b_valid = 1'b0; b_last = 1'b0; end
        else     begin a_valid = 1'b0; a_last = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] e;
        reset   = 1'b1;
        a_valid = 1'b0; a_last = 1'b0; a_abort = 1'b0; a_vc = 2'd0; a_data = 8'd0;
        b_valid = 1'b0; b_last = 1'b0; b_abort = 1'b0; b_vc = 2'd0; b_data = 8'd0;

        // ---- reset state, then idle stream ---------------------------------
        repeat (2) @(negedge clk);
        check("rst_sym",   32'({a_k, a_sym}), 32'(K_IDL));
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_err",   32'(a_err), 32'd0);
        check("rst_b_sym", 32'({b_k, b_sym}), 32'(K_IDL));
        @(posedge clk); #1;
        reset = 1'b0;
        // With SKP_INTERVAL=8 the first request lands 8 edges after release:
        // IDL at +9, COM at +10, SKP at +11..+13, and again 8 later.
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 10 || k == 18)                         e = K_COM;
            else if ((k >= 11 && k <= 13) || (k >= 19 && k <= 21)) e = K_SKP;
            else                                            e = K_IDL;
            check($sformatf("idle_b[%0d]", k), 32'({b_k, b_sym}), 32'(e));
            check($sformatf("idle_a[%0d]", k), 32'({a_k, a_sym}), 32'(K_IDL));
            check($sformatf("idle_rdy[%0d]", k), 32'(a_ready), 32'd0);
        end
        check("idle_err", 32'(a_err), 32'd0);

        // ---- 3-byte TLP on vc 2 --------------------------------------------
        do_reset();
        a_vc = 2'd2;
        push(1'b0, 8'h11, 1'b0);
        push(1'b0, 8'h22, 1'b0);
        push(1'b0, 8'h33, 1'b1);
        idle(4);
        exp_q = '{K_STP, 9'h002, 9'h011, 9'h022, 9'h033, K_END, K_IDL};
        check_stream("tlp3");
        check("tlp3_err", 32'(a_err), 32'd0);

        // ---- underrun gap of two cycles ------------------------------------
        do_reset();
        a_vc = 2'd1;
        push(1'b0, 8'h44, 1'b0);
        idle(2);
        push(1'b0, 8'h55, 1'b1);
        idle(4);
        exp_q = '{K_STP, 9'h001, 9'h044, K_PAD, K_PAD, 9'h055, K_END, K_IDL};
        check_stream("gap");

        // ---- last on exactly the MAX_LEN-th byte is legal ------------------
        do_reset();
        a_vc = 2'd0;
        push(1'b0, 8'hA1, 1'b0);
        push(1'b0, 8'hA2, 1'b0);
        push(1'b0, 8'hA3, 1'b0);
        push(1'b0, 8'hA4, 1'b1);
        idle(4);
        exp_q = '{K_STP, 9'h000, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, K_END, K_IDL};
        check_stream("maxlen_ok");
        check("maxlen_ok_err", 32'(a_err), 32'd0);

        // ---- overrun: 6 bytes, last only on the 6th ------------------------
        do_reset();
        a_vc = 2'd3;
        for (int i = 1; i <= 6; i++) push(1'b0, 8'(i), (i == 6));
        idle(4);
        exp_q = '{K_STP, 9'h003, 9'h001, 9'h002, 9'h003, 9'h004, K_OVR,
                  K_STP, 9'h003, 9'h005, 9'h006, K_END, K_IDL};
        check_stream("ovr");
        check("ovr_err", 32'(a_err), 32'd1);
        idle(6);
        check("ovr_err_sticky", 32'(a_err), 32'd1);

        // ---- abort together with last on the 2nd byte ----------------------
        do_reset();
        check("abort_err_clr", 32'(a_err), 32'd0);
        a_vc = 2'd3;
        push(1'b0, 8'h61, 1'b0);
        a_abort = 1'b1;
        push(1'b0, 8'h62, 1'b1);
        a_abort = 1'b0;
        idle(4);
`ifdef WRR_EDB_EN
        exp_q = '{K_STP, 9'h003, 9'h061, 9'h1DF, K_IDL};
`else
        exp_q = '{K_STP, 9'h003, 9'h061, 9'h062, K_END, K_IDL};
`endif
        check_stream("abort");
        check("abort_err", 32'(a_err), 32'd0);

        // ---- SKP placement: three back-to-back 10-byte frames on dut_b -----
        do_reset();
        b_vc = 2'd1;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 10; i++)
                push(1'b1, 8'(8'h10 + f * 10 + i), (i == 9));
        idle(8);
        begin
            int in_frame, hdr_next, frames, com_gap, pidx;
            in_frame = 0; hdr_next = 0; frames = 0; com_gap = 0; pidx = 0;
            for (int i = 0; i < cap_b.size(); i++) begin
                if (cap_b[i] == K_STP) begin
                    check("skp_stp_nested", 32'(in_frame), 32'd0);
                    if (frames > 0) check("skp_gap_has_com", 32'(com_gap >= 1), 32'd1);
                    in_frame = 1; hdr_next = 1;
                end else if (cap_b[i] == K_END) begin
                    in_frame = 0; frames++; com_gap = 0;
                end else if (cap_b[i] == K_COM) begin
                    check($sformatf("skp_com_in_frame@%0d", i), 32'(in_frame), 32'd0);
                    com_gap++;
                    for (int s = 1; s <= 3; s++)
                        if (i + s < cap_b.size())
                            check($sformatf("skp_set@%0d", i + s), 32'(cap_b[i + s]), 32'(K_SKP));
                end else if (in_frame != 0 && hdr_next != 0) begin
                    check("skp_hdr", 32'(cap_b[i]), 32'h001);
                    hdr_next = 0;
                end else if (in_frame != 0) begin
                    check($sformatf("skp_pay[%0d]", pidx), 32'(cap_b[i]), 32'(8'h10 + pidx));
                    pidx++;
                end
            end
            check("skp_frames", 32'(frames), 32'd3);
            check("skp_bytes",  32'(pidx), 32'd30);
        end
        check("skp_b_err", 32'(b_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wrr_tlp_framer.md
Name: wrr_tlp_framer

Overview:
- Downstream stage of the weighted-round-robin VC arbiter.
- Consumes the byte stream granted by the arbiter and frames each TLP on the lane as STP, a VC header byte, the payload bytes, then END.
- Fills gaps with IDL and inserts periodic SKP ordered sets (COM + 3×SKP) between frames.
- Output is one registered 8-bit symbol per clock plus a K-character flag.

Parameters:
- SKP_INTERVAL, 64: cycles between SKP ordered-set requests; legal range 8..1023.
- MAX_LEN, 32: maximum payload bytes per frame; legal range 1..255.

Ports:
- clk  input  1  single clock for all state.
- reset  input  1  asynchronous, active-high reset.
- grant_valid  input  1  arbiter has a byte for the granted VC.
- grant_vc  input  2  VC of the current grant; sampled only on the frame's first accepted cycle.
- grant_data  input  8  payload byte.
- grant_last  input  1  marks the final byte of the TLP.
- grant_abort  input  1  arbiter nullifies the TLP in flight; used only with WRR_EDB_EN.
- grant_ready  output  1  framer accepts grant_data this cycle.
- out_sym  output  8  lane symbol.
- out_k  output  1  1 = out_sym is a K/control symbol.
- frame_err  output  1  sticky; set on MAX_LEN overrun.

Behaviour:
- Symbol codes: COM BC, PAD C7, SKP AC, STP AA, END F6, EDB DF, IDL AE. The header byte is {6'b0, vc} and carries out_k=0.
- Reset (async assert, sync deassert, as applied by the bench):
  - out_sym=AE, out_k=1, grant_ready=0, frame_err=0.
  - state=IDLE, skp_cnt=0, skp_pend=0.
- All outputs are registered. A decision taken in cycle t appears on out_sym/out_k after edge t+1.
- States and transitions:
  - IDLE: emit IDL.
    - If skp_pend=1, go SKP0 (SKP has priority over a new frame).
    - Else if grant_valid=1, emit STP, latch grant_vc, go HDR.
  - HDR: emit {6'b0, vc_q}, go PAY. grant_ready=0 in IDLE/HDR, so no data is consumed before PAY.
  - PAY: grant_ready=1.
    - grant_valid=1: emit grant_data (k=0) and increment len_cnt. If grant_last=1, go END.
    - grant_valid=0: emit PAD (k=1) as underrun filler. len_cnt is unchanged. Stay in PAY.
  - END: emit END (k=1), clear len_cnt, go IDLE.
  - SKP0: emit COM. SKP1..SKP3: emit SKP. Then return to IDLE. grant_ready=0 throughout.
- Latency: grant_valid rising in IDLE gives STP at +1, header at +2. The first payload byte is accepted in the PAY cycle and appears one cycle later.
- SKP scheduling:
  - skp_cnt increments every cycle.
  - When skp_cnt reaches SKP_INTERVAL-1: set skp_pend, wrap skp_cnt to 0.
  - skp_pend clears on entry to SKP0.
  - SKP is never inserted inside a frame. A request raised mid-frame waits for IDLE.
  - A second expiry while skp_pend is already set is absorbed (no double set).
- Length guard: if len_cnt reaches MAX_LEN without grant_last:
  - grant_ready drops.
  - The next symbol is END (EDB with WRR_EDB_EN).
  - frame_err sets (sticky until reset).
  - The arbiter's remaining bytes are not consumed until the next frame.
- Simultaneous events:
  - grant_last together with the MAX_LEN-th byte is a legal frame; frame_err is not set.
  - grant_abort has priority over grant_last.
- Reset asserted mid-frame: output returns to IDL immediately; no END is emitted.

Optional Feature:
- Macro: WRR_EDB_EN.
- Defined:
  - grant_abort=1 in PAY ends the frame. The byte is not accepted, the next symbol is EDB (DF, k=1), and the state returns to IDLE.
  - MAX_LEN overrun also terminates the frame with EDB.
- Undefined:
  - grant_abort is ignored.
  - Overrun terminates the frame with END.
  - EDB is never emitted.

Test Plan:
- Reset held, then released with grant_valid=0 -> out_sym=AE, out_k=1 every cycle; grant_ready=0; frame_err=0.
- 3-byte TLP on vc=2 (11,22,33; last on 33) -> AA(k), 02, 11, 22, 33, F6(k), AE(k).
- grant_valid dropped for 2 cycles mid-payload of bytes 44,55 -> 44, C7(k), C7(k), 55, F6(k); no byte lost or duplicated.
- SKP_INTERVAL=8, continuous frames of 10 bytes -> BC, AC, AC, AC appear only between F6 and the next AA; never inside a frame.
- MAX_LEN=4, 6-byte TLP without last in the first 4 bytes -> 4 data bytes, then F6 (DF with WRR_EDB_EN); frame_err=1 stays set.
- With WRR_EDB_EN, grant_abort on the 2nd payload byte -> AA, hdr, byte1, DF(k), AE. Without the macro -> the same TLP completes with F6.
